// File: rtl/sr_cmd_sequencer_pkg.sv
// Shared definitions for the s/r command sequencer: FSM state encoding and default timing.
// Benches for the downstream sr_ff stage reuse the default parameter values.
package sr_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PULSE_S  = 3'd1,
    ST_PULSE_R  = 3'd2,
    ST_CONFLICT = 3'd3,
    ST_WAIT_REL = 3'd4
  } state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PULSE_W    = 2;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/sr_cmd_sequencer_debounce.sv
// Two-flop synchroniser, debounce counter and one-cycle rise strobe for one raw button.
module sr_cmd_sequencer_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_deb,
  output logic o_rise
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        // this edge is the DEB_CYCLES-th consecutive differing sample
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_rise = r_deb & ~r_deb_d;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns two bouncy operator buttons into clean, mutually exclusive fixed-width s/r pulses.
// Simultaneous or overlapping presses raise a one-cycle err instead of any pulse.
module sr_cmd_sequencer
  import sr_cmd_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_btn,
  input  logic             clr_btn,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] pulse_cnt
);

  logic             w_deb_set;
  logic             w_deb_clr;
  logic             w_rise_set;
  logic             w_rise_clr;
  logic             w_conflict;
  state_t           r_state;
  logic [CNT_W-1:0] r_pw;

  sr_cmd_sequencer_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_set (
    .clk(clk), .rst(rst), .i_btn(set_btn), .o_deb(w_deb_set), .o_rise(w_rise_set)
  );

  sr_cmd_sequencer_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_clr (
    .clk(clk), .rst(rst), .i_btn(clr_btn), .o_deb(w_deb_clr), .o_rise(w_rise_clr)
  );

  assign w_conflict = (w_rise_set & (w_rise_clr | w_deb_clr)) | (w_rise_clr & w_deb_set);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pw      <= '0;
      s         <= 1'b0;
      r         <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_conflict) begin
            r_state <= ST_CONFLICT;
            err     <= 1'b1;
            busy    <= 1'b1;
          end else if (w_rise_set || w_rise_clr) begin
            r_state <= w_rise_set ? ST_PULSE_S : ST_PULSE_R;
            s       <= w_rise_set;
            r       <= ~w_rise_set;
            busy    <= 1'b1;
            r_pw    <= CNT_W'(PULSE_W - 1);
            if (pulse_cnt != '1) pulse_cnt <= pulse_cnt + CNT_W'(1);
          end
        end
        ST_PULSE_S, ST_PULSE_R: begin
          if (r_pw == '0) begin
            r_state <= ST_WAIT_REL;
            s       <= 1'b0;
            r       <= 1'b0;
          end else begin
            r_pw <= r_pw - CNT_W'(1);
          end
        end
        ST_CONFLICT: begin
          r_state <= ST_WAIT_REL;
          err     <= 1'b0;
        end
        ST_WAIT_REL: begin
          // held buttons must be released before any new press can count
          if (!w_deb_set && !w_deb_clr) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          s       <= 1'b0;
          r       <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer with a sample-history reference model and literal spot checks.
module tb_sr_cmd_sequencer;

  localparam int DEB = 4;
  localparam int PW  = 2;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          set_btn = 1'b0;
  logic          clr_btn = 1'b0;
  logic          s, r, busy, err;
  logic [CW-1:0] pulse_cnt;

  sr_cmd_sequencer #(.DEB_CYCLES(DEB), .PULSE_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s), .r(r), .busy(busy), .err(err), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: raw samples are delayed two edges, a level flips once the
  // last DEB delayed samples all disagree with it, and the sequencer is a mode
  // with a remaining-cycle count.
  localparam int M_IDLE = 0, M_S = 1, M_R = 2, M_CONF = 3, M_WAIT = 4;
  int m_mode, m_left, m_cnt;
  bit m_rawq[2][$];
  bit m_hist[2][$];
  bit m_deb[2], m_deb_old[2];
  bit m_raw[2];
  bit m_rs, m_rc, m_ds, m_dc, m_used, m_flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_left = 0; m_cnt = 0;
      for (int b = 0; b < 2; b++) begin
        m_rawq[b] = {1'b0, 1'b0};
        m_hist[b] = {};
        m_deb[b] = 1'b0; m_deb_old[b] = 1'b0;
      end
    end else begin
      m_raw[0] = set_btn; m_raw[1] = clr_btn;
      m_rs = m_deb[0] && !m_deb_old[0];
      m_rc = m_deb[1] && !m_deb_old[1];
      m_ds = m_deb[0]; m_dc = m_deb[1];
      case (m_mode)
        M_IDLE: begin
          if ((m_rs && (m_rc || m_dc)) || (m_rc && m_ds)) m_mode = M_CONF;
          else if (m_rs || m_rc) begin
            m_mode = m_rs ? M_S : M_R;
            m_left = PW;
            m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          end
        end
        M_S, M_R: begin
          m_left--;
          if (m_left == 0) m_mode = M_WAIT;
        end
        M_CONF: m_mode = M_WAIT;
        default: if (!m_ds && !m_dc) m_mode = M_IDLE;
      endcase
      for (int b = 0; b < 2; b++) begin
        m_used = m_rawq[b].pop_front();
        m_rawq[b].push_back(m_raw[b]);
        m_deb_old[b] = m_deb[b];
        m_hist[b].push_back(m_used);
        if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
        m_flip = (m_hist[b].size() == DEB);
        foreach (m_hist[b][k]) if (m_hist[b][k] == m_deb[b]) m_flip = 1'b0;
        if (m_flip) begin
          m_deb[b] = ~m_deb[b];
          m_hist[b] = {};
        end
      end
    end
  end

  int s_cyc, r_cyc, err_cyc, busy_cyc;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s",         int'(s),         int'(m_mode == M_S));
      chk("r",         int'(r),         int'(m_mode == M_R));
      chk("busy",      int'(busy),      int'(m_mode != M_IDLE));
      chk("err",       int'(err),       int'(m_mode == M_CONF));
      chk("pulse_cnt", int'(pulse_cnt), m_cnt);
      chk("s_and_r",   int'(s & r),     0);
      s_cyc    += int'(s);
      r_cyc    += int'(r);
      err_cyc  += int'(err);
      busy_cyc += int'(busy);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    s_cyc = 0; r_cyc = 0; err_cyc = 0; busy_cyc = 0;
  endtask

  initial begin
    // 1: reset with both buttons high
    set_btn = 1'b1; clr_btn = 1'b1;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick(2);
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(pulse_cnt), 0);
    set_btn = 1'b0; clr_btn = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(8);

    // 2: clean set press, s exactly after edges 7 and 8
    clr_counts();
    set_btn = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      if (e == 6) chk("set_e6", int'(s), 0);
      if (e == 7) chk("set_e7", int'(s), 1);
      if (e == 8) chk("set_e8", int'(s), 1);
      if (e == 9) chk("set_e9", int'(s), 0);
    end
    tick(11);
    set_btn = 1'b0;
    tick(10);
    chk("set_s_cycles", s_cyc, 2);
    chk("set_r_cycles", r_cyc, 0);
    chk("set_cnt", int'(pulse_cnt), 1);
    chk("set_busy_end", int'(busy), 0);

    // 3: three-cycle glitch on clear is rejected
    clr_counts();
    clr_btn = 1'b1;
    tick(3);
    clr_btn = 1'b0;
    tick(10);
    chk("glitch_r_cycles", r_cyc, 0);
    chk("glitch_busy_cycles", busy_cyc, 0);
    chk("glitch_cnt", int'(pulse_cnt), 1);

    // 4: simultaneous press -> single err, park until release
    clr_counts();
    set_btn = 1'b1; clr_btn = 1'b1;
    tick(10);
    set_btn = 1'b0; clr_btn = 1'b0;
    tick(12);
    chk("conf_err_cycles", err_cyc, 1);
    chk("conf_sr_cycles", s_cyc + r_cyc, 0);
    chk("conf_busy_cycles", busy_cyc, 10);
    chk("conf_cnt", int'(pulse_cnt), 1);

    // 5: reset lands mid-pulse while set stays held
    set_btn = 1'b1;
    tick(7);
    chk("midrst_pre_s", int'(s), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_s", int'(s), 0);
    chk("midrst_cnt", int'(pulse_cnt), 0);
    tick(1);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      if (e == 6) chk("rel_e6", int'(s), 0);
      if (e == 7) chk("rel_e7", int'(s), 1);
    end
    set_btn = 1'b0;
    tick(12);
    chk("rel_cnt", int'(pulse_cnt), 1);

    // 6: alternating presses drive pulse_cnt into saturation
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) set_btn = 1'b1; else clr_btn = 1'b1;
      tick(12);
      set_btn = 1'b0; clr_btn = 1'b0;
      tick(10);
      if (i == 253) chk("sat_254", int'(pulse_cnt), 255);
    end
    chk("sat_final", int'(pulse_cnt), 255);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
